// File: rtl/mips_pipeline_param.sv
// 5-stage MIPS subset pipeline (add/sub/addi/lw/sw/beq/j). Unsupported encodings retire as NOPs.
// Define MIPS_FORWARDING_EN to forward EX/MEM and MEM/WB results into EX; otherwise RAW hazards stall in ID.
module mips_pipeline_param #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic              dmem_we,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              wb_valid,
    output logic [4:0]        wb_reg,
    output logic [DATA_W-1:0] wb_data,
    output logic              stall
);
    localparam int         RW    = $clog2(NREGS);
    localparam logic [4:0] RMASK = 5'(NREGS - 1);

    logic [ADDR_W-1:0] pc;
    logic [31:0]       id_instr;
    logic [ADDR_W-1:0] id_pc;

    logic              ex_we, ex_lw, ex_sw, ex_beq, ex_sub, ex_imm_sel;
    logic [4:0]        ex_dest;
    logic [DATA_W-1:0] ex_a, ex_b, ex_imm;
    logic [ADDR_W-1:0] ex_pc;

    logic              mem_we, mem_lw, mem_sw;
    logic [4:0]        mem_dest;
    logic [DATA_W-1:0] mem_alu, mem_store;

    logic              wb_we;
    logic [4:0]        wb_dest;
    logic [DATA_W-1:0] wb_val;

    logic [DATA_W-1:0] rf [NREGS];

    logic [5:0]        op, funct;
    logic [4:0]        rs, rt, rd, d_dest;
    logic              d_add, d_sub, d_addi, d_lw, d_sw, d_beq, d_j;
    logic              use_rs, use_rt, d_we, hazard, taken, bubble;
    logic [DATA_W-1:0] rs_val, rt_val, d_imm;
    logic [DATA_W-1:0] op_a, op_b, ex_res, mem_res;
    logic [ADDR_W-1:0] beq_target;

    always_comb begin
        op     = id_instr[31:26];
        funct  = id_instr[5:0];
        rs     = id_instr[25:21] & RMASK;
        rt     = id_instr[20:16] & RMASK;
        rd     = id_instr[15:11] & RMASK;
        d_add  = (op == 6'h00) && (funct == 6'h20);
        d_sub  = (op == 6'h00) && (funct == 6'h22);
        d_addi = (op == 6'h08);
        d_lw   = (op == 6'h23);
        d_sw   = (op == 6'h2B);
        d_beq  = (op == 6'h04);
        d_j    = (op == 6'h02);
        d_dest = (d_add || d_sub) ? rd : rt;
        d_we   = (d_add || d_sub || d_addi || d_lw) && (d_dest != 5'd0);
        use_rs = (d_add || d_sub || d_addi || d_lw || d_sw || d_beq) && (rs != 5'd0);
        use_rt = (d_add || d_sub || d_sw || d_beq) && (rt != 5'd0);
        d_imm  = DATA_W'($signed(id_instr[15:0]));
        // Write-first read: the value retiring this cycle wins over the stale array entry.
        rs_val = (wb_we && wb_dest == rs) ? wb_val : rf[rs[RW-1:0]];
        rt_val = (wb_we && wb_dest == rt) ? wb_val : rf[rt[RW-1:0]];
    end

    assign mem_res = mem_lw ? dmem_rdata : mem_alu;

`ifdef MIPS_FORWARDING_EN
    logic [4:0] ex_rs, ex_rt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_rs <= '0;
            ex_rt <= '0;
        end else begin
            ex_rs <= rs;
            ex_rt <= rt;
        end
    end

    always_comb begin
        op_a = ex_a;
        if (mem_we && mem_dest == ex_rs)     op_a = mem_res;
        else if (wb_we && wb_dest == ex_rs)  op_a = wb_val;
        op_b = ex_b;
        if (mem_we && mem_dest == ex_rt)     op_b = mem_res;
        else if (wb_we && wb_dest == ex_rt)  op_b = wb_val;
        hazard = ex_lw && ex_we &&
                 ((use_rs && rs == ex_dest) || (use_rt && rt == ex_dest));
    end
`else
    always_comb begin
        op_a   = ex_a;
        op_b   = ex_b;
        hazard = (ex_we  && ((use_rs && rs == ex_dest)  || (use_rt && rt == ex_dest))) ||
                 (mem_we && ((use_rs && rs == mem_dest) || (use_rt && rt == mem_dest)));
    end
`endif

    always_comb begin
        ex_res     = ex_sub ? (op_a - op_b) : (ex_imm_sel ? (op_a + ex_imm) : (op_a + op_b));
        taken      = ex_beq && (op_a == op_b);
        beq_target = ex_pc + ADDR_W'(1) + ex_imm[ADDR_W-1:0];
        bubble     = taken || hazard;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc         <= '0;
            id_instr   <= '0;
            id_pc      <= '0;
            ex_we      <= 1'b0;
            ex_lw      <= 1'b0;
            ex_sw      <= 1'b0;
            ex_beq     <= 1'b0;
            ex_sub     <= 1'b0;
            ex_imm_sel <= 1'b0;
            ex_dest    <= '0;
            ex_a       <= '0;
            ex_b       <= '0;
            ex_imm     <= '0;
            ex_pc      <= '0;
            mem_we     <= 1'b0;
            mem_lw     <= 1'b0;
            mem_sw     <= 1'b0;
            mem_dest   <= '0;
            mem_alu    <= '0;
            mem_store  <= '0;
            wb_we      <= 1'b0;
            wb_dest    <= '0;
            wb_val     <= '0;
        end else begin
            ex_we      <= d_we && !bubble;
            ex_lw      <= d_lw && !bubble;
            ex_sw      <= d_sw && !bubble;
            ex_beq     <= d_beq && !bubble;
            ex_sub     <= d_sub;
            ex_imm_sel <= d_addi || d_lw || d_sw;
            ex_dest    <= d_dest;
            ex_a       <= rs_val;
            ex_b       <= rt_val;
            ex_imm     <= d_imm;
            ex_pc      <= id_pc;

            mem_we     <= ex_we;
            mem_lw     <= ex_lw;
            mem_sw     <= ex_sw;
            mem_dest   <= ex_dest;
            mem_alu    <= ex_res;
            mem_store  <= op_b;

            wb_we      <= mem_we;
            wb_dest    <= mem_dest;
            wb_val     <= mem_res;

            // A taken beq in EX overrides both a stall and a j sitting in ID.
            if (taken) begin
                pc       <= beq_target;
                id_instr <= '0;
            end else if (!hazard) begin
                if (d_j) begin
                    pc       <= id_instr[ADDR_W-1:0];
                    id_instr <= '0;
                end else begin
                    pc       <= pc + ADDR_W'(1);
                    id_instr <= imem_rdata;
                    id_pc    <= pc;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else if (wb_we) begin
            rf[wb_dest[RW-1:0]] <= wb_val;
        end
    end

    assign imem_addr  = pc;
    assign dmem_addr  = mem_alu[ADDR_W-1:0];
    assign dmem_wdata = mem_store;
    assign dmem_we    = mem_sw && rst;
    assign wb_valid   = wb_we;
    assign wb_reg     = wb_dest;
    assign wb_data    = wb_val;
    assign stall      = hazard && !taken;
endmodule

// File: tb/tb_mips_pipeline_param.sv
// Bench for mips_pipeline_param: directed scenarios and random programs checked against an
// instruction-at-a-time reference interpreter (retire order, final data memory, store count).
`timescale 1ns/1ps
module tb_mips_pipeline_param;
`ifdef MIPS_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } ret_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic mem_clr = 1'b1;
    always #5 clk = ~clk;

    logic [9:0]  imem_addr, dmem_addr;
    logic [31:0] imem_rdata, dmem_wdata, dmem_rdata, wb_data;
    logic        dmem_we, wb_valid, stall;
    logic [4:0]  wb_reg;
    logic [31:0] imem [1024];
    logic [31:0] dmem [1024];

    logic [9:0]  imem_addr16, dmem_addr16;
    logic [31:0] imem_rdata16;
    logic [15:0] dmem_wdata16, dmem_rdata16, wb_data16;
    logic        dmem_we16, wb_valid16, stall16;
    logic [4:0]  wb_reg16;
    logic [31:0] imem16 [1024];
    logic [15:0] dmem16 [1024];

    mips_pipeline_param dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .stall(stall)
    );

    mips_pipeline_param #(.DATA_W(16)) dut16 (
        .clk(clk), .rst(rst), .imem_addr(imem_addr16), .imem_rdata(imem_rdata16),
        .dmem_addr(dmem_addr16), .dmem_wdata(dmem_wdata16), .dmem_we(dmem_we16), .dmem_rdata(dmem_rdata16),
        .wb_valid(wb_valid16), .wb_reg(wb_reg16), .wb_data(wb_data16), .stall(stall16)
    );

    assign imem_rdata   = imem[imem_addr];
    assign dmem_rdata   = dmem[dmem_addr];
    assign imem_rdata16 = imem16[imem_addr16];
    assign dmem_rdata16 = dmem16[dmem_addr16];

    ret_t trace[$];
    ret_t trace16[$];
    ret_t exp_q[$];
    logic [31:0] mm [1024];
    int stall_cnt = 0;
    int we_cnt = 0;
    int checks = 0;
    int errors = 0;

    always @(negedge clk) begin
        if (rst) begin
            if (wb_valid)   trace.push_back({wb_reg, wb_data});
            if (wb_valid16) trace16.push_back({wb_reg16, 16'h0, wb_data16});
            if (stall)      stall_cnt++;
        end
    end

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) begin
                dmem[i]   <= '0;
                dmem16[i] <= '0;
            end
        end else begin
            if (dmem_we) begin
                dmem[dmem_addr] <= dmem_wdata;
                we_cnt <= we_cnt + 1;
            end
            if (dmem_we16) dmem16[dmem_addr16] <= dmem_wdata16;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input int rd, input int rs, input int rt, input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rt, input int rs, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_j(input int tgt);
        return {6'h02, 26'(tgt)};
    endfunction

    function automatic logic [31:0] gen_instr(input int a, input int len);
        int rs = $urandom_range(0, 7);
        int rt = $urandom_range(0, 7);
        int rd = $urandom_range(0, 7);
        int k  = $urandom_range(0, 9);
        int off;
        case (k)
            0, 1:    return enc_r(rd, rs, rt, 6'h20);
            2:       return enc_r(rd, rs, rt, 6'h22);
            3, 4:    return enc_i(6'h08, rt, rs, $urandom_range(0, 65535));
            5:       return enc_i(6'h23, rt, rs, $urandom_range(0, 15));
            6:       return enc_i(6'h2B, rt, rs, $urandom_range(0, 15));
            7: begin
                off = $urandom_range(0, 3);
                if (a + 1 + off > len) off = len - a - 1;
                if ($urandom_range(0, 1) == 1) rt = rs;
                return enc_i(6'h04, rt, rs, off);
            end
            8: begin
                off = $urandom_range(1, 4);
                if (a + off > len) off = len - a;
                return enc_j(a + off);
            end
            default: return ($urandom_range(0, 1) == 1) ? enc_r(rd, rs, rt, 6'h21)
                                                         : enc_i(6'h0D, rt, rs, $urandom_range(0, 65535));
        endcase
    endfunction

    // Architectural interpreter: one instruction per step, no pipeline notion at all.
    task automatic run_model(input int len, output int nst);
        logic [31:0] r [32];
        logic [31:0] ins, a, b, imm, res;
        logic [9:0]  ea;
        int pc, np, wr, steps;
        exp_q.delete();
        nst = 0;
        for (int i = 0; i < 32; i++)   r[i] = '0;
        for (int i = 0; i < 1024; i++) mm[i] = '0;
        pc = 0;
        steps = 0;
        while (pc < len && steps < 500) begin
            ins = imem[pc];
            a   = r[ins[25:21]];
            b   = r[ins[20:16]];
            imm = 32'($signed(ins[15:0]));
            ea  = 10'(a + imm);
            res = '0;
            np  = (pc + 1) % 1024;
            wr  = -1;
            case (ins[31:26])
                6'h00: begin
                    if (ins[5:0] == 6'h20)      begin wr = int'(ins[15:11]); res = a + b; end
                    else if (ins[5:0] == 6'h22) begin wr = int'(ins[15:11]); res = a - b; end
                end
                6'h08: begin wr = int'(ins[20:16]); res = a + imm; end
                6'h23: begin wr = int'(ins[20:16]); res = mm[ea]; end
                6'h2B: begin mm[ea] = b; nst++; end
                6'h04: if (a == b) np = (pc + 1 + int'($signed(ins[15:0]))) & 1023;
                6'h02: np = int'(ins[9:0]);
                default: ;
            endcase
            if (wr > 0) begin
                r[wr] = res;
                exp_q.push_back({5'(wr), res});
            end
            pc = np;
            steps++;
        end
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 1024; i++) imem[i] = '0;
    endtask

    task automatic start();
        rst = 1'b0;
        mem_clr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mem_clr = 1'b0;
        rst = 1'b1;
    endtask

    initial begin
        int base, b16, s0, w0, first20, nst, bad, n;

        for (int i = 0; i < 1024; i++) imem16[i] = '0;
        imem16[0] = enc_i(6'h08, 1, 0, 16'hFFFF);
        imem16[1] = enc_i(6'h08, 1, 1, 1);
        imem16[2] = enc_i(6'h08, 0, 0, 7);

        clear_imem();
        imem[0] = enc_i(6'h08, 1, 0, 5);
        imem[1] = enc_i(6'h08, 2, 1, 3);
        imem[2] = enc_r(3, 1, 2, 6'h20);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pc",       64'(imem_addr), 64'd0);
        chk("rst_dmem_we",  64'(dmem_we),   64'd0);
        chk("rst_wb_valid", 64'(wb_valid),  64'd0);
        chk("rst_wb_reg",   64'(wb_reg),    64'd0);
        chk("rst_wb_data",  64'(wb_data),   64'd0);
        chk("rst_stall",    64'(stall),     64'd0);

        // Dependent addi/addi/add chain; the 16-bit instance runs its wrap/r0 program alongside.
        base = trace.size(); b16 = trace16.size(); s0 = stall_cnt;
        start();
        repeat (20) @(negedge clk);
        chk("chain_n",      64'(trace.size() - base), 64'd3);
        chk("chain_r1",     64'(trace[base]),     64'({5'd1, 32'd5}));
        chk("chain_r2",     64'(trace[base + 1]), 64'({5'd2, 32'd8}));
        chk("chain_r3",     64'(trace[base + 2]), 64'({5'd3, 32'd13}));
        chk("chain_stalls", 64'(stall_cnt - s0),  FWD ? 64'd0 : 64'd4);
        chk("w16_n",        64'(trace16.size() - b16), 64'd2);
        chk("w16_neg1",     64'(trace16[b16]),     64'({5'd1, 32'h0000FFFF}));
        chk("w16_wrap",     64'(trace16[b16 + 1]), 64'({5'd1, 32'h00000000}));

        // Store, load back, then use the load immediately.
        clear_imem();
        imem[0] = enc_i(6'h08, 1, 0, 42);
        imem[1] = enc_i(6'h2B, 1, 0, 7);
        imem[2] = enc_i(6'h23, 4, 0, 7);
        imem[3] = enc_r(5, 4, 4, 6'h20);
        base = trace.size(); s0 = stall_cnt; w0 = we_cnt;
        start();
        repeat (20) @(negedge clk);
        chk("ldst_mem7",   64'(dmem[7]),            64'h2A);
        chk("ldst_stores", 64'(we_cnt - w0),        64'd1);
        chk("ldst_n",      64'(trace.size() - base), 64'd3);
        chk("ldst_r4",     64'(trace[base + 1]),    64'({5'd4, 32'h2A}));
        chk("ldst_r5",     64'(trace[base + 2]),    64'({5'd5, 32'h54}));
        chk("ldst_stalls", 64'(stall_cnt - s0),     FWD ? 64'd1 : 64'd4);

        // Taken beq squashes the two following instructions.
        clear_imem();
        imem[0] = enc_i(6'h04, 0, 0, 2);
        imem[1] = enc_i(6'h08, 6, 0, 1);
        imem[2] = enc_i(6'h08, 7, 0, 1);
        imem[3] = enc_i(6'h08, 9, 0, 3);
        base = trace.size();
        start();
        repeat (20) @(negedge clk);
        chk("beq_n",    64'(trace.size() - base), 64'd1);
        chk("beq_next", 64'(trace[base]),         64'({5'd9, 32'd3}));

        // j at 3 to 20; the slot at 4 must not retire.
        clear_imem();
        imem[3]  = enc_j(20);
        imem[4]  = enc_i(6'h08, 8, 0, 9);
        imem[20] = enc_i(6'h08, 10, 0, 4);
        base = trace.size(); first20 = -1;
        start();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (imem_addr == 10'd20 && first20 < 0) first20 = c;
        end
        chk("j_fetch_cycle", 64'(first20),             64'd5);
        chk("j_n",           64'(trace.size() - base), 64'd1);
        chk("j_target",      64'(trace[base]),         64'({5'd10, 32'd4}));

        // Reset while a store sits in MEM: no write may land, state returns to zero.
        clear_imem();
        imem[0] = enc_i(6'h08, 1, 0, 16'h55);
        imem[4] = enc_i(6'h2B, 1, 0, 5);
        w0 = we_cnt;
        start();
        repeat (7) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("mid_rst_pc",       64'(imem_addr), 64'd0);
        chk("mid_rst_we",       64'(dmem_we),   64'd0);
        chk("mid_rst_wb_valid", 64'(wb_valid),  64'd0);
        chk("mid_rst_stall",    64'(stall),     64'd0);
        chk("mid_rst_no_store", 64'(we_cnt - w0), 64'd0);
        chk("mid_rst_mem5",     64'(dmem[5]),   64'd0);
        clear_imem();
        imem[0] = enc_r(2, 1, 1, 6'h20);
        base = trace.size();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (12) @(negedge clk);
        chk("mid_rst_n",  64'(trace.size() - base), 64'd1);
        chk("mid_rst_r1", 64'(trace[base]),         64'({5'd2, 32'd0}));

        // Random programs against the interpreter.
        for (int it = 0; it < 6; it++) begin
            clear_imem();
            for (int a = 0; a < 24; a++) imem[a] = gen_instr(a, 24);
            run_model(24, nst);
            base = trace.size(); w0 = we_cnt;
            start();
            repeat (4 * 24 + 20) @(negedge clk);
            n = trace.size() - base;
            chk($sformatf("rand%0d_n", it), 64'(n), 64'(exp_q.size()));
            for (int k = 0; k < exp_q.size() && k < n; k++)
                chk($sformatf("rand%0d_ret%0d", it, k), 64'(trace[base + k]), 64'(exp_q[k]));
            bad = 0;
            for (int i = 0; i < 1024; i++) if (dmem[i] !== mm[i]) bad++;
            chk($sformatf("rand%0d_dmem", it),   64'(bad),          64'd0);
            chk($sformatf("rand%0d_stores", it), 64'(we_cnt - w0),  64'(nst));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
